// File: rtl/store_trace_fifo_if.sv
// Store-trace bus: processor store strobe/payload in, show-ahead FIFO head and status out.
// master = processor/consumer side, slave = the FIFO.
interface store_trace_fifo_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = AW + 1;

   logic          MemWrite;
   logic [31:0]   ALUresult;
   logic [31:0]   WriteOnMem;
   logic          out_ready;
   logic          out_valid;
   logic [31:0]   out_addr;
   logic [31:0]   out_data;
   logic          out_misaligned;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [7:0]    drop_count;

   modport master (
      output MemWrite, ALUresult, WriteOnMem, out_ready,
      input  out_valid, out_addr, out_data, out_misaligned,
      input  level, full, empty, overflow, drop_count
   );

   modport slave (
      input  MemWrite, ALUresult, WriteOnMem, out_ready,
      output out_valid, out_addr, out_data, out_misaligned,
      output level, full, empty, overflow, drop_count
   );
endinterface

// File: rtl/store_trace_fifo.sv
// Show-ahead FIFO capturing processor data-memory stores for a trace consumer.
// Stores arriving while full (and not popping) are dropped and counted.
module store_trace_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input logic              CLK,
   input logic              reset,
   store_trace_fifo_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        misaligned;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_next;
   logic          full_q;
   logic          empty_q;
   logic          overflow_q;
   logic [7:0]    drop_q;
   logic          pop_c;
   logic          push_c;
   logic          drop_c;

   // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
   always_comb begin
      pop_c      = 1'b0;
      push_c     = 1'b0;
      drop_c     = 1'b0;
      pop_c      = !empty_q && bus.out_ready;
      push_c     = bus.MemWrite && (!full_q || pop_c);
      drop_c     = bus.MemWrite && full_q && !pop_c;
      level_next = level_q + LW'(push_c) - LW'(pop_c);
   end

   // Storage is not reset; occupancy tracking makes stale entries invisible.
   always_ff @(posedge CLK) begin
      if (push_c) begin
         mem[wr_ptr] <= '{addr:       bus.ALUresult,
                          data:       bus.WriteOnMem,
                          misaligned: |bus.ALUresult[1:0]};
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         level_q <= level_next;
         full_q  <= (level_next == LW'(DEPTH));
         empty_q <= (level_next == '0);
         if (drop_c) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
         end
      end
   end

   // Head is read straight from storage for zero-latency show-ahead.
   assign bus.out_valid      = !empty_q;
   assign bus.out_addr       = mem[rd_ptr].addr;
   assign bus.out_data       = mem[rd_ptr].data;
   assign bus.out_misaligned = mem[rd_ptr].misaligned;
   assign bus.level          = level_q;
   assign bus.full           = full_q;
   assign bus.empty          = empty_q;
   assign bus.overflow       = overflow_q;
   assign bus.drop_count     = drop_q;
endmodule

// File: doc/store_trace_fifo.md
STORE_TRACE_FIFO -- requirements
Module: store_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port MemWrite  input  1  processor data-memory write strobe, sampled each rising CLK edge.
REQ-005 SHALL have port ALUresult  input  32  store byte address from processor ALU.
REQ-006 SHALL have port WriteOnMem  input  32  store data from processor register file.
REQ-007 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_addr  output  32  head entry address.
REQ-010 SHALL have port out_data  output  32  head entry data.
REQ-011 SHALL have port out_misaligned  output  1  head entry address bits [1:0] were nonzero.
REQ-012 SHALL have port level  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have ports full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-014 SHALL have port overflow  output  1  sticky: a store was dropped since reset.
REQ-015 SHALL have port drop_count  output  8  number of dropped stores, saturating.

Function
REQ-016 SHALL push {ALUresult, WriteOnMem, ALUresult[1:0]!=0} on each rising edge where MemWrite=1 and (not full, or pop occurs same edge).
REQ-017 SHALL pop the head on each rising edge where out_valid=1 and out_ready=1.
REQ-018 SHALL be show-ahead: out_valid = !empty; out_addr/out_data/out_misaligned reflect the head combinationally from storage, with no extra register stage.
REQ-019 SHALL give push-to-visible latency of one edge: entry pushed at edge N drives out_valid=1 immediately after edge N if the FIFO was empty.
REQ-020 SHALL hold out_addr/out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL leave out_addr/out_data don't-care while out_valid=0; the bench SHALL NOT check them then.
REQ-022 SHALL, on simultaneous push and pop: level unchanged; when full, the push is accepted (not dropped); when empty, no pop occurs (out_valid=0) and the push proceeds.
REQ-023 SHALL, on MemWrite=1 while full with no pop: drop the store, set overflow=1, increment drop_count, and saturate drop_count at 255; FIFO contents are unchanged.
REQ-024 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH; level SHALL be tracked as a separate counter, 0..DEPTH.
REQ-025 SHALL preserve entry order exactly (first in, first out) across pointer wrap-around.
REQ-026 SHALL ignore ALUresult/WriteOnMem when MemWrite=0, including X values.

Reset
REQ-027 SHALL, on reset=1, asynchronously clear both pointers, level, overflow, and drop_count; out_valid=0, empty=1, full=0. Storage contents need not be cleared.
REQ-028 SHALL, on reset asserted mid-stream, discard all pending entries and ignore MemWrite and out_ready until reset is released.
REQ-029 SHALL resume normal capture on the first rising edge after reset deasserts.

Verification
REQ-030 SHALL verify single store: reset held 22 ns (CLK period 10 ns), then MemWrite=1, ALUresult=0x54, WriteOnMem=0x7 for one edge, out_ready=0 -> out_valid=1, out_addr=0x54, out_data=0x7, level=1, out_misaligned=0.
REQ-031 SHALL verify fill and overflow: 10 consecutive stores of addr 4*i, data i (i=0..9), out_ready=0 -> full=1, level=8, overflow=1, drop_count=2; drained order is data 0..7.
REQ-032 SHALL verify full with simultaneous push/pop: FIFO full, MemWrite=1 (data 0xAA), out_ready=1 -> level stays 8, overflow stays 0, 0xAA emerges last.
REQ-033 SHALL verify wrap-around: 20 stores interleaved with pops, out_ready toggling every cycle -> every datum is received once, in order; level never exceeds 8.
REQ-034 SHALL verify misaligned store: ALUresult=0x102 -> out_misaligned=1 at the head.
REQ-035 SHALL verify reset mid-stream: level=5, assert reset between edges -> out_valid=0, level=0, and drop_count=0 without waiting for a clock edge.
